reg_dest_queue: RTL and testbench

Parametrised successor to the multicycle datapath's register-destination select. Each issued instruction picks its write-back register number from five sources. Here the choice is latched into a FIFO of pending write-backs, so long-latency units (mult/div, memory) can retire in order. The block also reports a read-after-write hazard to the control unit while a source register still has a pending write. It sits between the instruction register and the register-file write port.

---
 rtl/reg_dest_queue_pkg.sv | 10 +
 rtl/reg_dest_queue_decode.sv | 26 ++
 rtl/reg_dest_queue.sv | 97 +++++++++
 tb/tb_reg_dest_queue.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/reg_dest_queue_pkg.sv
// reg_dest_queue_pkg: destination-select codes and fixed link/stack register numbers.
package reg_dest_queue_pkg;
    localparam logic [2:0] SEL_RT  = 3'b000;
    localparam logic [2:0] SEL_RD  = 3'b001;
    localparam logic [2:0] SEL_RA  = 3'b010;
    localparam logic [2:0] SEL_SP  = 3'b011;
    localparam logic [2:0] SEL_AUX = 3'b100;
    localparam int REG_RA = 31;
    localparam int REG_SP = 29;
endpackage

// File: rtl/reg_dest_queue_decode.sv
// reg_dest_decode: picks the write-back register number from the select code.
module reg_dest_decode
    import reg_dest_queue_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [2:0]        sel,
    input  logic [ADDR_W-1:0] field0,
    input  logic [ADDR_W-1:0] field1,
    input  logic [ADDR_W-1:0] field4,
    output logic [ADDR_W-1:0] dest,
    output logic              legal
);
    always_comb begin
        dest  = '0;
        legal = 1'b1;
        case (sel)
            SEL_RT:  dest = field0;
            SEL_RD:  dest = field1;
            SEL_RA:  dest = ADDR_W'(REG_RA);
            SEL_SP:  dest = ADDR_W'(REG_SP);
            SEL_AUX: dest = field4;
            default: legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/reg_dest_queue.sv
// reg_dest_queue: in-order FIFO of pending write-back destinations with a
// busy-map derived read-after-write hazard for the next instruction's sources.
module reg_dest_queue
    import reg_dest_queue_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [2:0]                 sel,
    input  logic [ADDR_W-1:0]          field0,
    input  logic [ADDR_W-1:0]          field1,
    input  logic [ADDR_W-1:0]          field4,
    input  logic                       push,
    output logic                       push_ready,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [ADDR_W-1:0]          head_dest,
    input  logic [ADDR_W-1:0]          src_a,
    input  logic [ADDR_W-1:0]          src_b,
    output logic                       hazard,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       illegal_sel
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0]   mem_d [DEPTH];
    logic [DEPTH-1:0]    vld_q, vld_d;
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ill_q, ill_d;
    logic [ADDR_W-1:0]   dest;
    logic                legal, acc, do_pop;
    logic [2**ADDR_W-1:0] busy;

    reg_dest_decode #(.ADDR_W(ADDR_W)) u_decode (
        .sel    (sel),
        .field0 (field0),
        .field1 (field1),
        .field4 (field4),
        .dest   (dest),
        .legal  (legal)
    );

    assign head_valid  = count_q != '0;
    assign push_ready  = (count_q < CW'(DEPTH)) || pop;
    assign acc         = push && push_ready && legal;
    assign do_pop      = pop && head_valid;
    assign head_dest   = head_valid ? mem_q[head_q] : '0;
    assign hazard      = busy[src_a] | busy[src_b];
    assign count       = count_q;
    assign illegal_sel = ill_q;

    // Pop is applied before push so a full-queue push+pop reuses the freed slot.
    always_comb begin
        mem_d = mem_q;
        vld_d = vld_q;
        if (do_pop) vld_d[head_q] = 1'b0;
        if (acc) begin
            mem_d[tail_q] = dest;
            vld_d[tail_q] = 1'b1;
        end
        head_d  = do_pop ? head_q + PW'(1) : head_q;
        tail_d  = acc ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(acc) - CW'(do_pop);
        ill_d   = push && !legal;
    end

    // Register 0 is hardwired, so entries targeting it never make it busy.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++)
            if (vld_q[i]) busy[mem_q[i]] = 1'b1;
        busy[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q   <= '{default: '0};
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ill_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ill_q   <= ill_d;
        end
    end
endmodule

// File: tb/tb_reg_dest_queue.sv
// tb_reg_dest_queue: directed and random stimulus against a queue-based
// reference model; expectations flow through a scoreboard to a negedge monitor.
module tb_reg_dest_queue;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [2:0]        sel;
    logic [ADDR_W-1:0] field0, field1, field4, src_a, src_b, head_dest;
    logic              push, pop, push_ready, head_valid, hazard, illegal_sel;
    logic [$clog2(DEPTH):0] count;

    reg_dest_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sel         (sel),
        .field0      (field0),
        .field1      (field1),
        .field4      (field4),
        .push        (push),
        .push_ready  (push_ready),
        .pop         (pop),
        .head_valid  (head_valid),
        .head_dest   (head_dest),
        .src_a       (src_a),
        .src_b       (src_b),
        .hazard      (hazard),
        .count       (count),
        .illegal_sel (illegal_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int hv;
        int hd;
        int hz;
        int pr;
        int il;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    int   model[$];
    exp_t sb[$];
    bit   prev_ill = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_busy(input int r);
        if (r == 0) return 1'b0;
        foreach (model[i]) if (model[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input bit p, input int s, input int f0, input int f1, input int f4,
                         input bit pp, input int a, input int b);
        exp_t e;
        bit   legal, acc;
        int   dst;
        @(posedge clk);
        #1;
        push = p; sel = 3'(s); field0 = 5'(f0); field1 = 5'(f1); field4 = 5'(f4);
        pop = pp; src_a = 5'(a); src_b = 5'(b);
        e.cnt = model.size();
        e.hv  = model.size() > 0;
        e.hd  = model.size() > 0 ? model[0] : 0;
        e.hz  = is_busy(a) || is_busy(b);
        e.pr  = (model.size() < DEPTH) || pp;
        e.il  = prev_ill;
        sb.push_back(e);
        legal = s <= 4;
        dst = s == 0 ? f0 : s == 1 ? f1 : s == 2 ? 31 : s == 3 ? 29 : f4;
        acc = p && legal && (model.size() < DEPTH || pp);
        if (pp && model.size() > 0) void'(model.pop_front());
        if (acc) model.push_back(dst);
        prev_ill = p && !legal;
    endtask

    task automatic idle(input bit pp, input int a, input int b);
        drive(1'b0, 0, 0, 0, 0, pp, a, b);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("count",       int'(count),       e.cnt);
            chk("head_valid",  int'(head_valid),  e.hv);
            chk("head_dest",   int'(head_dest),   e.hd);
            chk("hazard",      int'(hazard),      e.hz);
            chk("push_ready",  int'(push_ready),  e.pr);
            chk("illegal_sel", int'(illegal_sel), e.il);
        end
    end

    task automatic async_reset();
        @(negedge clk);
        #2;
        push = 1'b0; pop = 1'b0; src_a = 5'd8; src_b = 5'd31;
        reset_n = 1'b0;
        #1;
        chk("rst_count",       int'(count),       0);
        chk("rst_head_valid",  int'(head_valid),  0);
        chk("rst_head_dest",   int'(head_dest),   0);
        chk("rst_hazard",      int'(hazard),      0);
        chk("rst_push_ready",  int'(push_ready),  1);
        chk("rst_illegal_sel", int'(illegal_sel), 0);
        model.delete();
        prev_ill = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        push = 1'b0; pop = 1'b0; sel = '0;
        field0 = '0; field1 = '0; field4 = '0; src_a = '0; src_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        idle(0, 0, 0);
        idle(0, 0, 0);
        // Fill with 8, 31, 29, 12 and observe full.
        drive(1, 0, 8, 0, 0, 0, 8, 0);
        drive(1, 2, 0, 0, 0, 0, 31, 0);
        drive(1, 3, 0, 0, 0, 0, 0, 29);
        drive(1, 4, 0, 0, 12, 0, 12, 0);
        idle(0, 12, 0);
        drive(1, 1, 0, 5, 0, 1, 5, 8);
        repeat (4) idle(1, 5, 0);
        idle(0, 5, 0);
        // Duplicate destination stays busy until its last entry leaves.
        drive(1, 0, 9, 0, 0, 0, 9, 0);
        drive(1, 0, 9, 0, 0, 0, 9, 0);
        idle(1, 9, 0);
        idle(1, 9, 0);
        idle(0, 9, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0);
        idle(1, 0, 0);
        // Undefined select and empty pop.
        drive(1, 6, 3, 3, 3, 0, 3, 0);
        idle(0, 3, 0);
        idle(0, 3, 0);
        drive(1, 7, 3, 3, 3, 1, 3, 0);
        idle(1, 0, 0);
        idle(0, 0, 0);
        // Reset mid-fill.
        drive(1, 0, 8, 0, 0, 0, 8, 0);
        drive(1, 2, 0, 0, 0, 0, 8, 0);
        drive(1, 3, 0, 0, 0, 0, 8, 0);
        async_reset();
        idle(0, 8, 31);
        for (int n = 0; n < 1200; n++) begin
            int a, b;
            a = $urandom_range(0, 9);
            b = $urandom_range(0, 9);
            a = a == 8 ? 29 : a == 9 ? 31 : a;
            b = b == 8 ? 29 : b == 9 ? 31 : b;
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1) == 1, a, b);
        end
        idle(0, 0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
